zone_moisture_scanner: RTL and testbench

//  Consumes the 2-bit slot index from the free-running 2-bit binary counter and uses it as a

---
 rtl/irrigation_pkg.sv | 16 +
 rtl/sync_2ff.sv | 25 ++
 rtl/zone_moisture_scanner.sv | 127 ++++++++++++
 tb/tb_zone_moisture_scanner.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/irrigation_pkg.sv
// Shared irrigation constants: zone count and zone-index width, common to the
// slot counter, this scanner and the irrigation controller.
package irrigation_pkg;

  localparam int NUM_ZONES = 4;
  localparam int ZONE_W    = 2;

  // Lowest-index set bit of a zone vector (0 when the vector is empty).
  function automatic logic [ZONE_W-1:0] lowest_index(input logic [NUM_ZONES-1:0] v);
    lowest_index = '0;
    for (int i = NUM_ZONES - 1; i >= 0; i--) begin
      if (v[i]) lowest_index = ZONE_W'(i);
    end
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchroniser for an asynchronous input.
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops give the first stage a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/zone_moisture_scanner.sv
// Time-division moisture scanner: synchronises four sensor bits, debounces the
// zone selected by the slot index, and reports stable-flag changes on a
// valid/ready event stream. Also flags any slot sequence that is not +1 per clock.
module zone_moisture_scanner
  import irrigation_pkg::*;
#(
  parameter int DEBOUNCE = 4,
  parameter int CNT_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [ZONE_W-1:0]    slot,
  input  logic [NUM_ZONES-1:0] sensor_dry,
  output logic [NUM_ZONES-1:0] zone_dry,
  output logic                 evt_valid,
  output logic [ZONE_W-1:0]    evt_zone,
  output logic                 evt_dry,
  input  logic                 evt_ready,
  output logic                 seq_err
);

  logic [NUM_ZONES-1:0] s;
  logic [NUM_ZONES-1:0] zone_dry_q, zone_dry_d;
  logic [CNT_W-1:0]     cnt_q [NUM_ZONES];
  logic [CNT_W-1:0]     cnt_d [NUM_ZONES];
  logic [NUM_ZONES-1:0] flip;
  logic [NUM_ZONES-1:0] pending_q, pending_d;
  logic                 evt_valid_q, evt_valid_d;
  logic [ZONE_W-1:0]    evt_zone_q, evt_zone_d;
  logic                 evt_dry_q, evt_dry_d;
  logic                 load;
  logic [ZONE_W-1:0]    pick;
  logic [ZONE_W-1:0]    prev_slot_q;
  logic                 armed_q;
  logic                 seq_err_q;

  // ---- stage: sensor synchronisation ----
  for (genvar k = 0; k < NUM_ZONES; k++) begin : g_sync
    sync_2ff u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (sensor_dry[k]),
      .q_o   (s[k])
    );
  end

  // ---- stage: debounce of the zone owning the current slot ----
  // Only the slotted zone's counter moves; all others hold.
  always_comb begin
    zone_dry_d = zone_dry_q;
    cnt_d      = cnt_q;
    flip       = '0;
    if (s[slot] != zone_dry_q[slot]) begin
      if (cnt_q[slot] == CNT_W'(DEBOUNCE - 1)) begin
        zone_dry_d[slot] = ~zone_dry_q[slot];
        cnt_d[slot]      = '0;
        flip[slot]       = 1'b1;
      end else begin
        cnt_d[slot] = cnt_q[slot] + 1'b1;
      end
    end else begin
      cnt_d[slot] = '0;
    end
  end

  // ---- stage: event register and pending set ----
  // Lowest pending zone loads when the slot is empty or being accepted;
  // a fresh flip re-sets its pending bit even if it is cleared this cycle.
  always_comb begin
    load        = !evt_valid_q || evt_ready;
    pick        = lowest_index(pending_q);
    pending_d   = pending_q;
    evt_valid_d = evt_valid_q;
    evt_zone_d  = evt_zone_q;
    evt_dry_d   = evt_dry_q;
    if (load) begin
      if (|pending_q) begin
        evt_valid_d     = 1'b1;
        evt_zone_d      = pick;
        evt_dry_d       = zone_dry_q[pick];
        pending_d[pick] = 1'b0;
      end else begin
        evt_valid_d = 1'b0;
      end
    end
    pending_d = pending_d | flip;
  end

  // State registers for debounce, pending set and event slot.
  always_ff @(posedge clk) begin
    if (reset) begin
      zone_dry_q  <= '0;
      pending_q   <= '0;
      evt_valid_q <= 1'b0;
      evt_zone_q  <= '0;
      evt_dry_q   <= 1'b0;
      for (int i = 0; i < NUM_ZONES; i++) cnt_q[i] <= '0;
    end else begin
      zone_dry_q  <= zone_dry_d;
      pending_q   <= pending_d;
      evt_valid_q <= evt_valid_d;
      evt_zone_q  <= evt_zone_d;
      evt_dry_q   <= evt_dry_d;
      cnt_q       <= cnt_d;
    end
  end

  // Slot sequence monitor; the first cycle after reset only arms the check.
  always_ff @(posedge clk) begin
    if (reset) begin
      prev_slot_q <= '0;
      armed_q     <= 1'b0;
      seq_err_q   <= 1'b0;
    end else begin
      prev_slot_q <= slot;
      armed_q     <= 1'b1;
      if (armed_q && (slot != ZONE_W'(prev_slot_q + 1'b1))) seq_err_q <= 1'b1;
    end
  end

  assign zone_dry  = zone_dry_q;
  assign evt_valid = evt_valid_q;
  assign evt_zone  = evt_zone_q;
  assign evt_dry   = evt_dry_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_zone_moisture_scanner.sv
// Bench for zone_moisture_scanner: directed scenarios plus a random phase,
// every cycle compared against a behavioural model of the scanner.
module tb_zone_moisture_scanner;

  localparam int DEBOUNCE = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] slot;
  logic [3:0] sensor_dry;
  logic [3:0] zone_dry;
  logic       evt_valid;
  logic [1:0] evt_zone;
  logic       evt_dry;
  logic       evt_ready;
  logic       seq_err;

  int vectors     = 0;
  int miscompares = 0;

  zone_moisture_scanner #(.DEBOUNCE(DEBOUNCE), .CNT_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .slot       (slot),
    .sensor_dry (sensor_dry),
    .zone_dry   (zone_dry),
    .evt_valid  (evt_valid),
    .evt_zone   (evt_zone),
    .evt_dry    (evt_dry),
    .evt_ready  (evt_ready),
    .seq_err    (seq_err)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  logic [3:0] m_s1 = '0, m_s2 = '0;
  logic [3:0] m_flag = '0;
  int         m_run [4] = '{0, 0, 0, 0};
  logic [3:0] m_pend = '0;
  logic       m_v = 1'b0;
  logic [1:0] m_zone = '0;
  logic       m_dry = 1'b0;
  logic [1:0] m_prev = '0;
  logic       m_armed = 1'b0;
  logic       m_err = 1'b0;

  // Accepted events observed on the DUT port: {zone, dry}
  logic [2:0] hs [$];

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    logic [3:0] n_s1, n_s2, n_flag, n_pend;
    int         n_run [4];
    logic       n_v, n_dry, n_armed, n_err;
    logic [1:0] n_zone, n_prev, n_slot;
    int         k, first;
    if (!reset && evt_valid && evt_ready) hs.push_back({evt_zone, evt_dry});
    if (reset) begin
      n_s1 = '0; n_s2 = '0; n_flag = '0; n_pend = '0;
      n_run = '{0, 0, 0, 0};
      n_v = 1'b0; n_zone = '0; n_dry = 1'b0;
      n_prev = '0; n_armed = 1'b0; n_err = 1'b0;
      n_slot = '0;
    end else begin
      n_s1 = sensor_dry; n_s2 = m_s1;
      n_flag = m_flag; n_run = m_run; n_pend = m_pend;
      n_v = m_v; n_zone = m_zone; n_dry = m_dry;
      k = int'(slot);
      if (!m_v || evt_ready) begin
        first = -1;
        for (int j = 0; j < 4; j++) if (m_pend[j] && first < 0) first = j;
        if (first >= 0) begin
          n_v = 1'b1; n_zone = 2'(first); n_dry = m_flag[first]; n_pend[first] = 1'b0;
        end else begin
          n_v = 1'b0;
        end
      end
      // A zone needs DEBOUNCE consecutive differing own-slot samples to flip
      if (m_s2[k] != m_flag[k]) begin
        if (m_run[k] + 1 >= DEBOUNCE) begin
          n_flag[k] = ~m_flag[k]; n_run[k] = 0; n_pend[k] = 1'b1;
        end else begin
          n_run[k] = m_run[k] + 1;
        end
      end else begin
        n_run[k] = 0;
      end
      n_err   = m_err | (m_armed && (slot != 2'(m_prev + 1)));
      n_prev  = slot;
      n_armed = 1'b1;
      n_slot  = slot + 2'd1;
    end
    @(posedge clk);
    #1;
    m_s1 = n_s1; m_s2 = n_s2; m_flag = n_flag; m_run = n_run; m_pend = n_pend;
    m_v = n_v; m_zone = n_zone; m_dry = n_dry;
    m_prev = n_prev; m_armed = n_armed; m_err = n_err;
    slot = n_slot;
    chk("zone_dry",  8'(zone_dry),  8'(m_flag));
    chk("evt_valid", 8'(evt_valid), 8'(m_v));
    chk("evt_zone",  8'(evt_zone),  8'(m_zone));
    chk("evt_dry",   8'(evt_dry),   8'(m_dry));
    chk("seq_err",   8'(seq_err),   8'(m_err));
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_slot(input logic [1:0] want);
    int n;
    n = 0;
    while (slot != want && n < 8) begin
      tick();
      n++;
    end
    chk("slot_align", 8'(slot), 8'(want));
  endtask

  initial begin
    int         lat;
    logic [3:0] mask;
    logic       all_dry;

    reset = 1'b1; slot = '0; sensor_dry = '0; evt_ready = 1'b1;
    ticks(2);
    chk("rst_zone_dry",  8'(zone_dry), 8'h00);
    chk("rst_evt_valid", 8'(evt_valid), 8'h00);
    chk("rst_seq_err",   8'(seq_err), 8'h00);
    reset = 1'b0;

    // Idle: nothing must change for 100 clocks
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("idle_zone_dry",  8'(zone_dry), 8'h00);
      chk("idle_evt_valid", 8'(evt_valid), 8'h00);
      chk("idle_seq_err",   8'(seq_err), 8'h00);
    end

    // Zone 2 goes dry and stays dry
    hs.delete();
    sensor_dry[2] = 1'b1;
    lat = 0;
    while (!zone_dry[2] && lat < 30) begin
      tick();
      lat++;
    end
    chk("z2_latency_in_window", 8'(lat >= 15 && lat <= 18), 8'h01);
    ticks(10);
    chk("z2_event_count", 8'(hs.size()), 8'h01);
    if (hs.size() > 0) chk("z2_event", 8'(hs[0]), 8'({2'd2, 1'b1}));

    // Short pulse on zone 1 is rejected
    hs.delete();
    sensor_dry[1] = 1'b1;
    ticks(10);
    sensor_dry[1] = 1'b0;
    ticks(20);
    chk("glitch_zone1", 8'(zone_dry[1]), 8'h00);
    chk("glitch_events", 8'(hs.size()), 8'h00);

    // Return to all-wet, then stall while all four zones go dry
    sensor_dry = 4'b0000;
    ticks(40);
    chk("clear_zone_dry", 8'(zone_dry), 8'h00);
    wait_slot(2'd2);
    evt_ready = 1'b0;
    sensor_dry = 4'b1111;
    ticks(20);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("stall_valid", 8'(evt_valid), 8'h01);
      chk("stall_zone",  8'(evt_zone), 8'h00);
      chk("stall_dry",   8'(evt_dry), 8'h01);
    end
    chk("stall_zone_dry", 8'(zone_dry), 8'h0F);
    evt_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("burst_valid", 8'(evt_valid), 8'h01);
      chk("burst_zone",  8'(evt_zone), 8'(i));
      chk("burst_dry",   8'(evt_dry), 8'h01);
      tick();
    end
    chk("burst_done", 8'(evt_valid), 8'h00);

    // Random sensor activity with random back-pressure
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 23) == 0) sensor_dry[$urandom_range(0, 3)] ^= 1'b1;
      evt_ready = ($urandom_range(0, 3) != 0);
      tick();
    end

    // Slot sequence 0,1,3 trips the sticky error; debouncing continues
    evt_ready = 1'b1;
    sensor_dry = 4'b1111;
    ticks(40);
    wait_slot(2'd1);
    tick();
    slot = 2'd3;
    tick();
    chk("seq_err_set", 8'(seq_err), 8'h01);
    ticks(20);
    chk("seq_err_sticky", 8'(seq_err), 8'h01);
    sensor_dry = 4'b0000;
    ticks(30);
    chk("track_after_err_0", 8'(zone_dry), 8'h00);
    sensor_dry = 4'b1111;
    ticks(30);
    chk("track_after_err_F", 8'(zone_dry), 8'h0F);
    chk("seq_err_still", 8'(seq_err), 8'h01);

    // Reset with zone_dry=1010 and a stalled event
    evt_ready = 1'b0;
    sensor_dry = 4'b1010;
    ticks(30);
    chk("pre_rst_zone_dry", 8'(zone_dry), 8'h0A);
    chk("pre_rst_stalled", 8'(evt_valid), 8'h01);
    reset = 1'b1;
    tick();
    chk("mid_rst_zone_dry",  8'(zone_dry), 8'h00);
    chk("mid_rst_evt_valid", 8'(evt_valid), 8'h00);
    chk("mid_rst_evt_zone",  8'(evt_zone), 8'h00);
    chk("mid_rst_evt_dry",   8'(evt_dry), 8'h00);
    chk("mid_rst_seq_err",   8'(seq_err), 8'h00);
    reset = 1'b0;
    evt_ready = 1'b1;
    hs.delete();
    ticks(40);
    chk("post_rst_zone_dry", 8'(zone_dry), 8'h0A);
    chk("post_rst_events", 8'(hs.size()), 8'h02);
    mask = '0;
    all_dry = 1'b1;
    foreach (hs[i]) begin
      mask[hs[i][2:1]] = 1'b1;
      all_dry &= hs[i][0];
    end
    chk("post_rst_zones", 8'(mask), 8'h0A);
    chk("post_rst_dry", 8'(all_dry), 8'h01);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
